freq_lock_detector: RTL

- Consumes the kHz frequency word produced by the clock monitor, which runs on the same 50 MHz reference clock.
- Samples that word once per gate window and tracks min/max statistics.
- Runs a lock-detection state machine that reports whether the measured clock is absent, settling, or stable.
- Feeds the status/readout register bank for the probe clock input.

---
 rtl/freq_lock_detector_if.sv | 26 ++
 rtl/freq_lock_detector.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/freq_lock_detector_if.sv
// Bus between the clock monitor side and the lock detector.
// master drives the frequency word and clear; slave publishes status.
interface freq_lock_detector_if;
    logic [31:0] count;
    logic        clear_stats;
    logic [31:0] freq;
    logic [31:0] freq_min;
    logic [31:0] freq_max;
    logic        stats_valid;
    logic        sample_valid;
    logic        locked;
    logic        lost;
    logic [1:0]  state;

    modport master (
        output count, clear_stats,
        input  freq, freq_min, freq_max, stats_valid,
        input  sample_valid, locked, lost, state
    );

    modport slave (
        input  count, clear_stats,
        output freq, freq_min, freq_max, stats_valid,
        output sample_valid, locked, lost, state
    );
endinterface

// File: rtl/freq_lock_detector.sv
// Samples the monitor's kHz word once per gate window, keeps min/max
// statistics and tracks lock of the measured clock.
module freq_lock_detector #(
    parameter int WINDOW     = 200000,
    parameter int TOLERANCE  = 2,
    parameter int LOCK_COUNT = 4
) (
    input logic                 clk,
    input logic                 rst,
    freq_lock_detector_if.slave bus
);
    typedef enum logic [1:0] {
        NOCLK   = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    localparam logic [31:0] WIN_LAST = 32'(WINDOW - 1);
    localparam logic [31:0] TOL      = 32'(TOLERANCE);
    localparam logic [3:0]  LOCK_N   = 4'(LOCK_COUNT);

    state_e      state_q, state_n;
    logic [31:0] win_ctr;
    logic [31:0] s;
    logic        cap_v;
    logic [31:0] ref_q, ref_n;
    logic [3:0]  cnt_q, cnt_n;
    logic        lost_n;
    logic [31:0] dev;
    logic        in_tol;
    logic [3:0]  cnt_inc;

    assign dev     = (s >= ref_q) ? (s - ref_q) : (ref_q - s);
    assign in_tol  = (dev <= TOL);
    assign cnt_inc = cnt_q + 4'd1;

    // Capture stage: s and cap_v feed the publishing edge one cycle later.
    always_ff @(posedge clk) begin
        if (!rst) begin
            win_ctr <= '0;
            s       <= '0;
            cap_v   <= 1'b0;
        end else begin
            cap_v <= (win_ctr == WIN_LAST);
            if (win_ctr == WIN_LAST) begin
                win_ctr <= '0;
                s       <= bus.count;
            end else begin
                win_ctr <= win_ctr + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= NOCLK;
            ref_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            ref_q   <= ref_n;
            cnt_q   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state_q;
        ref_n   = ref_q;
        cnt_n   = cnt_q;
        lost_n  = 1'b0;
        if (cap_v) begin
            unique case (state_q)
                NOCLK: begin
                    if (s != '0) begin
                        state_n = ACQUIRE;
                        ref_n   = s;
                        cnt_n   = 4'd1;
                    end
                end
                ACQUIRE: begin
                    if (s == '0) begin
                        state_n = NOCLK;
                        cnt_n   = '0;
                    end else if (in_tol) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == LOCK_N) state_n = LOCKED;
                    end else begin
                        ref_n = s;
                        cnt_n = 4'd1;
                    end
                end
                LOCKED: begin
                    if (s == '0) begin
                        state_n = NOCLK;
                        cnt_n   = '0;
                        lost_n  = 1'b1;
                    end else if (!in_tol) begin
                        state_n = ACQUIRE;
                        ref_n   = s;
                        cnt_n   = 4'd1;
                        lost_n  = 1'b1;
                    end
                end
                default: begin
                    state_n = NOCLK;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Clear is applied before a coincident sample so the sample reseeds.
    logic        base_v;
    logic [31:0] base_min, base_max;
    assign base_v   = bus.clear_stats ? 1'b0 : bus.stats_valid;
    assign base_min = bus.clear_stats ? '0 : bus.freq_min;
    assign base_max = bus.clear_stats ? '0 : bus.freq_max;

    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.freq         <= '0;
            bus.sample_valid <= 1'b0;
            bus.lost         <= 1'b0;
            bus.freq_min     <= '0;
            bus.freq_max     <= '0;
            bus.stats_valid  <= 1'b0;
        end else begin
            bus.sample_valid <= cap_v;
            bus.lost         <= lost_n;
            if (cap_v) bus.freq <= s;
            bus.stats_valid <= base_v;
            bus.freq_min    <= base_min;
            bus.freq_max    <= base_max;
            if (cap_v && s != '0) begin
                bus.stats_valid <= 1'b1;
                if (!base_v) begin
                    bus.freq_min <= s;
                    bus.freq_max <= s;
                end else begin
                    if (s < base_min) bus.freq_min <= s;
                    if (s > base_max) bus.freq_max <= s;
                end
            end
        end
    end

    assign bus.locked = (state_q == LOCKED);
    assign bus.state  = state_q;
endmodule
